// File: rtl/dsp_op_sequencer_if.sv
// Operation handshake and EXE2 control bundle between IPPro decode and the DSP op sequencer.
interface dsp_op_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             OP_VALID;
    logic             OP_READY;
    logic [3:0]       OP_CODE;
    logic [CNT_W-1:0] OP_COUNT;
    logic             OPND_VALID;
    logic             OPND_TAKE;
    logic [6:0]       OPMODE;
    logic [3:0]       ALUMODE;
    logic             CEA2;
    logic             CEB2;
    logic             CEC;
    logic             CEM;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    // Decode side: issues operations and supplies operands
    modport master (
        output OP_VALID, OP_CODE, OP_COUNT, OPND_VALID,
        input  OP_READY, OPND_TAKE, OPMODE, ALUMODE, CEA2, CEB2, CEC, CEM, BUSY, DONE, ERR
    );

    // Sequencer side
    modport slave (
        input  OP_VALID, OP_CODE, OP_COUNT, OPND_VALID,
        output OP_READY, OPND_TAKE, OPMODE, ALUMODE, CEA2, CEB2, CEC, CEM, BUSY, DONE, ERR
    );
endinterface

// File: rtl/dsp_op_sequencer.sv
// DSP48E1 control micro-sequencer: accepts one operation, issues its iterations into EXE2
// (inserting bubbles while operands are late), waits out the DSP pipeline, then pulses DONE.
// Optional feature macro: DSPSEQ_MAC_EN compiles in MAC/ACC opcodes and the iteration counter.
module dsp_op_sequencer #(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    dsp_op_sequencer_if.slave bus
);
    localparam int unsigned DRN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
`ifdef DSPSEQ_MAC_EN
    localparam logic [3:0] OP_MAC = 4'd4;
    localparam logic [3:0] OP_ACC = 4'd5;
`endif

    localparam logic [6:0] OPM_IDLE = 7'h20;

    typedef enum logic [1:0] {IDLE, EXEC, DRAIN, DONE_ST} state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [DRN_W-1:0] drn_cnt;
`ifdef DSPSEQ_MAC_EN
    logic [CNT_W-1:0] iter_cnt;
    logic             first_q;
`endif

    // Opcodes this build knows how to sequence
    function automatic logic op_legal(input logic [3:0] code);
`ifdef DSPSEQ_MAC_EN
        return code <= OP_ACC;
`else
        return code <= OP_MUL;
`endif
    endfunction

    // Ready only while idle and the pipeline is running
    assign bus.OP_READY = (state == IDLE) & ENABLE & ~RESET;

    // Sequencer FSM with registered EXE2 controls; ENABLE=0 freezes everything
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            op_q          <= OP_NOP;
            drn_cnt       <= '0;
`ifdef DSPSEQ_MAC_EN
            iter_cnt      <= '0;
            first_q       <= 1'b0;
`endif
            bus.OPMODE    <= OPM_IDLE;
            bus.ALUMODE   <= 4'b0000;
            bus.CEA2      <= 1'b0;
            bus.CEB2      <= 1'b0;
            bus.CEC       <= 1'b0;
            bus.CEM       <= 1'b0;
            bus.OPND_TAKE <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.ERR       <= 1'b0;
        end else if (ENABLE) begin
            bus.OPMODE    <= OPM_IDLE;
            bus.ALUMODE   <= 4'b0000;
            bus.CEA2      <= 1'b0;
            bus.CEB2      <= 1'b0;
            bus.CEC       <= 1'b0;
            bus.CEM       <= 1'b0;
            bus.OPND_TAKE <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.ERR       <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.OP_VALID) begin
                        if (!op_legal(bus.OP_CODE)) begin
                            bus.ERR <= 1'b1;
                        end else begin
                            op_q     <= bus.OP_CODE;
                            bus.BUSY <= 1'b1;
                            state    <= (bus.OP_CODE == OP_NOP) ? DONE_ST : EXEC;
`ifdef DSPSEQ_MAC_EN
                            first_q  <= 1'b1;
                            // Load N-1; a zero count still runs one iteration
                            iter_cnt <= (bus.OP_COUNT == '0) ? '0 : bus.OP_COUNT - CNT_W'(1);
`endif
                        end
                    end
                end

                EXEC: begin
                    if (bus.OPND_VALID) begin
                        bus.OPND_TAKE <= 1'b1;
                        case (op_q)
                            OP_ADD, OP_SUB: begin
                                bus.OPMODE  <= 7'h33;
                                bus.ALUMODE <= (op_q == OP_SUB) ? 4'b0011 : 4'b0000;
                                bus.CEA2    <= 1'b1;
                                bus.CEB2    <= 1'b1;
                                bus.CEC     <= 1'b1;
                            end
                            OP_MUL: begin
                                bus.OPMODE <= 7'h05;
                                bus.CEA2   <= 1'b1;
                                bus.CEB2   <= 1'b1;
                                bus.CEM    <= 1'b1;
                            end
`ifdef DSPSEQ_MAC_EN
                            OP_MAC: begin
                                bus.OPMODE <= first_q ? 7'h05 : 7'h25;
                                bus.CEA2   <= 1'b1;
                                bus.CEB2   <= 1'b1;
                                bus.CEM    <= 1'b1;
                            end
                            OP_ACC: begin
                                bus.OPMODE <= first_q ? 7'h03 : 7'h23;
                                bus.CEA2   <= 1'b1;
                                bus.CEB2   <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
`ifdef DSPSEQ_MAC_EN
                        first_q <= 1'b0;
                        if (iter_cnt != '0) begin
                            iter_cnt <= iter_cnt - CNT_W'(1);
                        end else begin
                            state   <= DRAIN;
                            drn_cnt <= DRN_W'(PIPE_DEPTH - 1);
                        end
`else
                        state   <= DRAIN;
                        drn_cnt <= DRN_W'(PIPE_DEPTH - 1);
`endif
                    end
                end

                DRAIN: begin
                    if (drn_cnt == '0) begin
                        state <= DONE_ST;
                    end else begin
                        drn_cnt <= drn_cnt - DRN_W'(1);
                    end
                end

                DONE_ST: begin
                    bus.DONE <= 1'b1;
                    bus.BUSY <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Self-checking bench for dsp_op_sequencer: reset checks, a vector table of operations with
// scripted operand/enable patterns, randomized operations against a transaction-level model,
// and a reset-in-flight sequence.
`timescale 1ns/1ps
module tb_dsp_op_sequencer;
    localparam int unsigned PD = 3;
    localparam int unsigned CW = 8;

    localparam int PH_EXEC   = 0;
    localparam int PH_DRAIN  = 1;
    localparam int PH_DONE   = 2;
    localparam int PH_POST   = 3;
    localparam int PH_ERRCLR = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic ENABLE;

    dsp_op_sequencer_if #(.CNT_W(CW)) bus ();

    dsp_op_sequencer #(.PIPE_DEPTH(PD), .CNT_W(CW)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [6:0] opmode;
        logic [3:0] alumode;
        logic       cea2;
        logic       ceb2;
        logic       cec;
        logic       cem;
        logic       take;
        logic       busy;
        logic       done;
        logic       err;
        logic       ready;
    } outs_t;

    typedef struct {
        logic [3:0]    code;
        logic [CW-1:0] cnt;
        logic [63:0]   ov_pat;
        logic [63:0]   en_pat;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    outs_t exp;

    function automatic bit mac_build();
`ifdef DSPSEQ_MAC_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit legal(input logic [3:0] code);
        return (code <= 4'd3) || (mac_build() && code <= 4'd5);
    endfunction

    function automatic outs_t idle_outs();
        outs_t o;
        o = '0;
        o.opmode = 7'h20;
        return o;
    endfunction

    // Controls for one issued iteration, straight from the opcode table
    function automatic outs_t iter_outs(input logic [3:0] code, input bit first);
        outs_t o;
        o = idle_outs();
        o.take = 1'b1;
        o.busy = 1'b1;
        case (code)
            4'd1: begin o.opmode = 7'h33; o.alumode = 4'b0000; o.cea2 = 1; o.ceb2 = 1; o.cec = 1; end
            4'd2: begin o.opmode = 7'h33; o.alumode = 4'b0011; o.cea2 = 1; o.ceb2 = 1; o.cec = 1; end
            4'd3: begin o.opmode = 7'h05; o.cea2 = 1; o.ceb2 = 1; o.cem = 1; end
            4'd4: begin o.opmode = first ? 7'h05 : 7'h25; o.cea2 = 1; o.ceb2 = 1; o.cem = 1; end
            4'd5: begin o.opmode = first ? 7'h03 : 7'h23; o.cea2 = 1; o.ceb2 = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.opmode  = bus.OPMODE;
        o.alumode = bus.ALUMODE;
        o.cea2    = bus.CEA2;
        o.ceb2    = bus.CEB2;
        o.cec     = bus.CEC;
        o.cem     = bus.CEM;
        o.take    = bus.OPND_TAKE;
        o.busy    = bus.BUSY;
        o.done    = bus.DONE;
        o.err     = bus.ERR;
        o.ready   = bus.OP_READY;
        return o;
    endfunction

    task automatic check(input string name);
        outs_t act;
        act = sample();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got opm=%h alu=%b ce=%b%b%b%b take=%b busy=%b done=%b err=%b rdy=%b, expected opm=%h alu=%b ce=%b%b%b%b take=%b busy=%b done=%b err=%b rdy=%b",
                     name, act.opmode, act.alumode, act.cea2, act.ceb2, act.cec, act.cem,
                     act.take, act.busy, act.done, act.err, act.ready,
                     exp.opmode, exp.alumode, exp.cea2, exp.ceb2, exp.cec, exp.cem,
                     exp.take, exp.busy, exp.done, exp.err, exp.ready);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One operation from acceptance until the sequencer is idle again, checked every cycle.
    // Bit k of ov_pat/en_pat is OPND_VALID/ENABLE for the k-th edge after acceptance.
    task automatic run_op(input logic [3:0] code, input logic [CW-1:0] cnt,
                          input logic [63:0] ov_pat, input logic [63:0] en_pat, input string name);
        int  n_iter;
        int  issued;
        int  dr;
        int  ph;
        int  k;
        bit  fin;
        bit  lg;
        logic en;
        logic ov;

        lg     = legal(code);
        n_iter = ((code == 4'd4 || code == 4'd5) && cnt != '0) ? int'(cnt) : 1;
        issued = 0;
        dr     = 0;
        fin    = 1'b0;

        ENABLE         = 1'b1;
        bus.OP_VALID   = 1'b1;
        bus.OP_CODE    = code;
        bus.OP_COUNT   = cnt;
        bus.OPND_VALID = 1'b0;
        #1;
        exp       = idle_outs();
        exp.ready = 1'b1;
        check($sformatf("%s ready_before_accept", name));

        step();
        bus.OP_VALID = 1'b0;
        bus.OP_CODE  = 4'($urandom);
        bus.OP_COUNT = CW'($urandom);
        exp       = idle_outs();
        exp.busy  = lg;
        exp.err   = !lg;
        exp.ready = !lg;
        if (!lg)                ph = PH_ERRCLR;
        else if (code == 4'd0)  ph = PH_DONE;
        else                    ph = PH_EXEC;
        check($sformatf("%s accept", name));

        k = 0;
        while (!fin && k < 200) begin
            en = (k < 64) ? en_pat[k] : 1'b1;
            ov = (k < 64) ? ov_pat[k] : 1'b1;
            ENABLE         = en;
            bus.OPND_VALID = ov;
            step();
            if (en) begin
                case (ph)
                    PH_EXEC: begin
                        if (ov) begin
                            exp = iter_outs(code, issued == 0);
                            issued++;
                            if (issued == n_iter) begin
                                ph = PH_DRAIN;
                                dr = 0;
                            end
                        end else begin
                            exp      = idle_outs();
                            exp.busy = 1'b1;
                        end
                    end
                    PH_DRAIN: begin
                        exp      = idle_outs();
                        exp.busy = 1'b1;
                        dr++;
                        if (dr == int'(PD)) ph = PH_DONE;
                    end
                    PH_DONE: begin
                        exp      = idle_outs();
                        exp.done = 1'b1;
                        ph       = PH_POST;
                    end
                    default: begin
                        exp = idle_outs();
                        fin = 1'b1;
                    end
                endcase
            end
            exp.ready = en && (ph == PH_POST || ph == PH_ERRCLR);
            check($sformatf("%s edge%0d", name, k));
            k++;
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: op not finished after %0d edges, required finish", name, k);
        end
        ENABLE         = 1'b1;
        bus.OPND_VALID = 1'b0;
    endtask

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t        tbl[11];
    logic [3:0]  rcode;
    logic [CW-1:0] rcnt;
    logic [63:0] rov;
    logic [63:0] ren;
    logic [3:0]  mcode;

    initial begin
        RESET          = 1'b1;
        ENABLE         = 1'b1;
        bus.OP_VALID   = 1'b0;
        bus.OP_CODE    = 4'd0;
        bus.OP_COUNT   = '0;
        bus.OPND_VALID = 1'b0;

        // Reset values, including reset winning over a pause
        step();
        exp       = idle_outs();
        exp.ready = 1'b0;
        check("reset_values");
        ENABLE = 1'b0;
        step();
        check("reset_over_pause");
        RESET  = 1'b0;
        ENABLE = 1'b1;
        #1;
        exp.ready = 1'b1;
        check("ready_after_reset");

        tbl[0]  = '{4'd3, 8'd0, ALL1, ALL1};                      // MUL
        tbl[1]  = '{4'd4, 8'd4, 64'hFFFF_FFFF_FFFF_FFFD, ALL1};   // MAC, stall on 2nd EXEC cycle
        tbl[2]  = '{4'd2, 8'd0, ALL1, ALL1};                      // SUB
        tbl[3]  = '{4'd1, 8'd7, ALL1, ALL1};                      // ADD ignores count
        tbl[4]  = '{4'd9, 8'd0, ALL1, ALL1};                      // illegal
        tbl[5]  = '{4'd5, 8'd0, ALL1, ALL1};                      // ACC count 0 -> one iteration
        tbl[6]  = '{4'd4, 8'd3, ALL1, 64'hFFFF_FFFF_FFFF_F3E3};   // MAC with pause mid-op and on DONE
        tbl[7]  = '{4'd0, 8'd5, ALL1, ALL1};                      // NOP
        tbl[8]  = '{4'd4, 8'd2, ALL1, ALL1};                      // MAC (illegal when not built in)
        tbl[9]  = '{4'd15, 8'd1, ALL1, 64'hFFFF_FFFF_FFFF_FFF8};  // illegal, ERR held by pause
        tbl[10] = '{4'd5, 8'd3, 64'hFFFF_FFFF_FFFF_FFF2, ALL1};   // ACC with bubbles

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].code, tbl[i].cnt, tbl[i].ov_pat, tbl[i].en_pat, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            rcode = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
            rcnt  = CW'($urandom_range(0, 10));
            rov   = {$urandom, $urandom} | {$urandom, $urandom};
            ren   = {$urandom, $urandom} | {$urandom, $urandom} | {$urandom, $urandom};
            run_op(rcode, rcnt, rov, ren, $sformatf("rnd%0d", i));
            step();
            exp       = idle_outs();
            exp.ready = 1'b1;
            check($sformatf("rnd%0d idle_gap", i));
        end

        // Reset during an operation: reset values next edge, and no DONE afterwards
        mcode          = mac_build() ? 4'd4 : 4'd3;
        bus.OP_VALID   = 1'b1;
        bus.OP_CODE    = mcode;
        bus.OP_COUNT   = 8'd5;
        bus.OPND_VALID = 1'b0;
        step();
        bus.OP_VALID   = 1'b0;
        bus.OPND_VALID = mac_build();
        step();
        step();
        if (mac_build()) begin
            exp = iter_outs(4'd4, 1'b0);
        end else begin
            exp      = idle_outs();
            exp.busy = 1'b1;
        end
        check("mid_op_before_reset");
        RESET  = 1'b1;
        ENABLE = 1'b0;
        step();
        exp = idle_outs();
        check("mid_op_reset");
        RESET          = 1'b0;
        ENABLE         = 1'b1;
        bus.OPND_VALID = 1'b1;
        exp.ready      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("no_done_after_reset%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dsp_op_sequencer.md
# dsp_op_sequencer

Micro-sequencer that drives the DSP48E1 control fields (OPMODE, ALUMODE, CEA2, CEB2, CEC, CEM) into the EXE2 stage for single-cycle and multi-cycle arithmetic operations. It accepts one operation per handshake and issues N per-cycle iterations, inserting hold bubbles when operands are late. It then waits out the DSP pipeline and signals completion. It sits between the IPPro decode stage and EXE2, and shares the pipeline ENABLE pause signal.

## Interface
Parameters:
- PIPE_DEPTH, 3: cycles from a registered control output to a valid P result; minimum 1.
- CNT_W, 8: width of the iteration count.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high; dominates every other input.
- ENABLE  in  1  pipeline enable; 0 = pause, all state and outputs frozen.
- OP_VALID  in  1  operation request.
- OP_READY  out  1  sequencer can accept an operation.
- OP_CODE  in  4  operation select, sampled on acceptance.
- OP_COUNT  in  CNT_W  iteration count for MAC/ACC, sampled on acceptance; 0 is treated as 1.
- OPND_VALID  in  1  A/B (and C) operands present for the current iteration.
- OPND_TAKE  out  1  the current iteration consumed its operands.
- OPMODE  out  7  to EXE2 OPMODE.
- ALUMODE  out  4  to EXE2 ALUMODE.
- CEA2, CEB2, CEC, CEM  out  1 each  to the EXE2 clock enables.
- BUSY  out  1  state is not IDLE.
- DONE  out  1  one-cycle pulse: the P result is valid.
- ERR  out  1  one-cycle pulse: an illegal opcode was accepted.

## Operation
- Acceptance happens on a cycle with OP_VALID & OP_READY & ENABLE. OP_READY = (state==IDLE) & ENABLE & ~RESET.
- Opcodes and their iteration 0 / later-iteration controls:
  - 0 NOP: no EXEC or DRAIN. DONE pulses the cycle after acceptance.
  - 1 ADD: OPMODE 7'h33 (Z=C, X=A:B), ALUMODE 4'b0000, CEA2=CEB2=CEC=1, CEM=0. N=1.
  - 2 SUB: as ADD, but ALUMODE 4'b0011 (C−A:B).
  - 3 MUL: OPMODE 7'h05, ALUMODE 0, CEA2=CEB2=CEM=1, CEC=0. N=1.
  - 4 MAC: iteration 0 uses OPMODE 7'h05; later iterations use 7'h25 (P+M). CEA2=CEB2=CEM=1. N=OP_COUNT.
  - 5 ACC: iteration 0 uses OPMODE 7'h03; later iterations use 7'h23 (P+A:B). CEA2=CEB2=1. N=OP_COUNT.
  - 6–15: illegal. ERR pulses the next cycle, the sequencer stays in IDLE, and DONE does not assert.
- FSM states: IDLE → EXEC → DRAIN → IDLE. NOP goes IDLE → DONE_ST → IDLE.
  - IDLE: OP_READY=1.
  - EXEC: runs one iteration per ENABLE cycle when OPND_VALID=1. When OPND_VALID=0, it outputs a bubble and the iteration index does not advance.
  - After the last iteration is issued, the FSM moves to DRAIN. DRAIN lasts PIPE_DEPTH cycles, then DONE pulses and the FSM returns to IDLE.
- Bubble and idle controls: OPMODE 7'h20 (P+0), ALUMODE 0, all CE=0, OPND_TAKE=0. Use these in IDLE, DRAIN, on a bubble, and after reset.
- OPND_TAKE=1 on every cycle that issues a real iteration.
- Iteration counter is CNT_W bits and counts N−1 down to 0. It cannot wrap because OP_COUNT=0 maps to 1.
- All outputs are registered. The controls for a cycle are computed from the state and OPND_VALID of the previous cycle.

## Timing
- Reset values: OPMODE=7'h20, ALUMODE=0, CEA2=CEB2=CEC=CEM=0, OPND_TAKE=0, BUSY=0, DONE=0, ERR=0, state=IDLE.
- RESET mid-operation returns to IDLE with the reset values on the next edge. No DONE pulse.
- Acceptance is at edge t. The sequencer is in EXEC from t+1, and the first iteration's controls appear after edge t+1 if OPND_VALID=1 at t+1.
- No-stall latency from acceptance to DONE is 1 + N + PIPE_DEPTH cycles.
- ENABLE=0 holds every register: state, counters, controls, DONE and ERR. A pending DONE pulse is extended until ENABLE returns. OPND_VALID is ignored while paused.
- RESET=1 and ENABLE=0 together: reset wins.
- A new operation is accepted no earlier than the cycle after DONE.

## Configuration
- DSPSEQ_MAC_EN defined: opcodes 4 (MAC) and 5 (ACC) are compiled in, together with the iteration counter.
- DSPSEQ_MAC_EN undefined: opcodes 4 and 5 are illegal (ERR pulse, no EXEC), N is always 1, and the counter logic is removed. OP_COUNT is unused.

## Test plan
- Reset then MUL: RESET 2 cycles, then MUL with OPND_VALID=1 → one cycle of OPMODE 7'h05 and CEM=1, DONE exactly 1+1+3=5 cycles after acceptance, outputs back to 7'h20 with all CE=0.
- MAC with stalls: MAC with OP_COUNT=4 and OPND_VALID low on the 2nd EXEC cycle → OPMODE sequence 05,20,25,25,25, OPND_TAKE high 4 times, DONE 9 cycles after acceptance.
- SUB/ADD: SUB → OPMODE 7'h33, ALUMODE 4'b0011, CEC=1; ADD → ALUMODE 0; OP_READY low throughout BUSY.
- Edge cases: opcode 9 → ERR one cycle, BUSY never set. ACC with OP_COUNT=0 → single iteration, OPMODE 7'h03.
- Pause: ENABLE low for 3 cycles in mid-MAC (OP_COUNT=3) and again on the DONE cycle → all outputs frozen during each pause, DONE extended until ENABLE returns, total iterations still 3.
- RESET mid-MAC after iteration 2 → reset values next cycle, no DONE. Without DSPSEQ_MAC_EN, opcode 4 → ERR.
